bus_scoreboard: RTL and testbench

- Checker-side counterpart of the bus delay line in the formal/verification auxiliary logic.
- Accepts expected words on a write port and DUT result words on a read port, and matches them in order through an internal FIFO.
- Reports per-word match/mismatch, sticky protocol faults and counters.
- Allows DUT latency to vary, up to MAX_LAT cycles, instead of being a fixed pipeline delay.

---
 rtl/bus_scoreboard.sv | 132 +++++++++++++
 tb/tb_bus_scoreboard.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_scoreboard.sv
// In-order scoreboard: expected words queue up in a FIFO and are popped and
// compared against DUT results that may arrive up to MAX_LAT cycles late.
module bus_scoreboard #(
  parameter int WIDTH   = 10,
  parameter int DEPTH   = 8,
  parameter int MAX_LAT = 15
) (
  input  logic                       clk,
  input  logic                       arst_n,
  input  logic                       exp_valid,
  input  logic [WIDTH-1:0]           exp_data,
  input  logic                       act_valid,
  input  logic [WIDTH-1:0]           act_data,
  output logic                       match,
  output logic                       mismatch,
  output logic                       fault,
  output logic                       overflow,
  output logic                       underflow,
  output logic                       timeout,
  output logic [$clog2(DEPTH):0]     level,
  output logic [15:0]                pass_cnt,
  output logic [15:0]                err_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int AW = $clog2(MAX_LAT + 1);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
  localparam logic [AW-1:0] AGE_MAX    = AW'(MAX_LAT);

  typedef enum logic [1:0] {IDLE, ACTIVE, FAULT} state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [AW-1:0]    age;

  logic             empty;
  logic             full;
  logic             pop;
  logic             push;
  logic             ovf_ev;
  logic             udf_ev;
  logic             tmo_ev;
  logic             neq;
  logic             err_ev;
  logic [LW-1:0]    level_nxt;

  // Full/empty come from the occupancy count so wrapped pointers never alias.
  always_comb begin
    empty     = (level == '0);
    full      = (level == FULL_LEVEL);
    pop       = act_valid && !empty;
    push      = exp_valid && (!full || pop);
    ovf_ev    = exp_valid && full && !pop;
    udf_ev    = act_valid && empty;
    tmo_ev    = !empty && !pop && (age == AGE_MAX);
    neq       = (mem[rd_ptr] != act_data);
    err_ev    = ovf_ev || udf_ev || tmo_ev || (pop && neq);
    level_nxt = level;
    if (push && !pop) begin
      level_nxt = level + LW'(1);
    end else if (pop && !push) begin
      level_nxt = level - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= exp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      age       <= '0;
      match     <= 1'b0;
      mismatch  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      timeout   <= 1'b0;
      pass_cnt  <= '0;
      err_cnt   <= '0;
    end else begin
      level    <= level_nxt;
      match    <= pop && !neq;
      mismatch <= pop && neq;
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (pop && !neq && pass_cnt != 16'hFFFF) begin
        pass_cnt <= pass_cnt + 16'd1;
      end
      if (pop && neq && err_cnt != 16'hFFFF) begin
        err_cnt <= err_cnt + 16'd1;
      end
      // Age tracks how long the current head has waited for its result.
      if (empty || pop) begin
        age <= '0;
      end else if (age != AGE_MAX) begin
        age <= age + AW'(1);
      end
      if (ovf_ev) begin
        overflow <= 1'b1;
      end
      if (udf_ev) begin
        underflow <= 1'b1;
      end
      if (tmo_ev) begin
        timeout <= 1'b1;
      end
      if (err_ev || state == FAULT) begin
        state <= FAULT;
      end else if (level_nxt != '0) begin
        state <= ACTIVE;
      end else begin
        state <= IDLE;
      end
    end
  end

  assign fault = (state == FAULT);

endmodule

// File: tb/tb_bus_scoreboard.sv
// Directed bench for bus_scoreboard: a queue-based reference model is checked
// against the DUT every cycle, plus literal expectations at key points.
module tb_bus_scoreboard;

  localparam int WIDTH   = 10;
  localparam int DEPTH   = 8;
  localparam int MAX_LAT = 15;

  logic             clk;
  logic             arst_n;
  logic             exp_valid;
  logic [WIDTH-1:0] exp_data;
  logic             act_valid;
  logic [WIDTH-1:0] act_data;
  logic             match;
  logic             mismatch;
  logic             fault;
  logic             overflow;
  logic             underflow;
  logic             timeout;
  logic [3:0]       level;
  logic [15:0]      pass_cnt;
  logic [15:0]      err_cnt;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 0;

  bus_scoreboard #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_LAT(MAX_LAT)) dut (
    .clk(clk), .arst_n(arst_n),
    .exp_valid(exp_valid), .exp_data(exp_data),
    .act_valid(act_valid), .act_data(act_data),
    .match(match), .mismatch(mismatch), .fault(fault),
    .overflow(overflow), .underflow(underflow), .timeout(timeout),
    .level(level), .pass_cnt(pass_cnt), .err_cnt(err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: a queue of pending expected words and plain flags.
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] front;
  int  m_age, m_pass, m_err, lvl;
  bit  m_match, m_mismatch, m_ovf, m_udf, m_tmo, m_fault, do_pop;

  always @(posedge clk) begin
    if (!arst_n) begin
      q.delete();
      m_age = 0; m_pass = 0; m_err = 0;
      m_match = 0; m_mismatch = 0;
      m_ovf = 0; m_udf = 0; m_tmo = 0; m_fault = 0;
    end else begin
      lvl = q.size();
      do_pop = act_valid && (lvl > 0);
      m_match = 0;
      m_mismatch = 0;
      if (act_valid && lvl == 0) m_udf = 1;
      if (do_pop) begin
        front = q.pop_front();
        if (front == act_data) begin
          m_match = 1;
          if (m_pass < 65535) m_pass++;
        end else begin
          m_mismatch = 1;
          if (m_err < 65535) m_err++;
        end
      end
      if (lvl > 0 && !do_pop && m_age == MAX_LAT) m_tmo = 1;
      if (lvl == 0 || do_pop) m_age = 0;
      else if (m_age < MAX_LAT) m_age++;
      if (exp_valid) begin
        if (lvl < DEPTH || do_pop) q.push_back(exp_data);
        else m_ovf = 1;
      end
      if (m_mismatch || m_ovf || m_udf || m_tmo) m_fault = 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("cyc_match", 32'(match), 32'(m_match));
      checkOutput("cyc_mismatch", 32'(mismatch), 32'(m_mismatch));
      checkOutput("cyc_fault", 32'(fault), 32'(m_fault));
      checkOutput("cyc_overflow", 32'(overflow), 32'(m_ovf));
      checkOutput("cyc_underflow", 32'(underflow), 32'(m_udf));
      checkOutput("cyc_timeout", 32'(timeout), 32'(m_tmo));
      checkOutput("cyc_level", 32'(level), 32'(q.size()));
      checkOutput("cyc_pass_cnt", 32'(pass_cnt), 32'(m_pass));
      checkOutput("cyc_err_cnt", 32'(err_cnt), 32'(m_err));
    end
  end

  task automatic applyStimulus(input bit ev, input logic [WIDTH-1:0] ed,
                               input bit av, input logic [WIDTH-1:0] ad);
    exp_valid = ev;
    exp_data  = ed;
    act_valid = av;
    act_data  = ad;
    @(negedge clk);
  endtask

  task automatic doReset();
    arst_n = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, '0);
    arst_n = 1'b1;
  endtask

  initial begin
    arst_n = 1'b0;
    exp_valid = 1'b0; exp_data = '0; act_valid = 1'b0; act_data = '0;
    doReset();
    chk_en = 1;
    checkOutput("rst_level", 32'(level), 0);
    checkOutput("rst_pass", 32'(pass_cnt), 0);
    checkOutput("rst_fault", 32'(fault), 0);

    // In-order matches with the DUT lagging two cycles behind.
    applyStimulus(1'b1, 10'h155, 1'b0, '0);
    applyStimulus(1'b1, 10'h2AA, 1'b0, '0);
    applyStimulus(1'b1, 10'h001, 1'b1, 10'h155);
    checkOutput("t1_match0", 32'(match), 1);
    applyStimulus(1'b0, '0, 1'b1, 10'h2AA);
    applyStimulus(1'b0, '0, 1'b1, 10'h001);
    checkOutput("t1_match2", 32'(match), 1);
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("t1_pass", 32'(pass_cnt), 3);
    checkOutput("t1_err", 32'(err_cnt), 0);
    checkOutput("t1_fault", 32'(fault), 0);
    checkOutput("t1_level", 32'(level), 0);
    checkOutput("t1_match_off", 32'(match), 0);

    // A mismatch makes fault sticky while later pairs still match.
    applyStimulus(1'b1, 10'h0F0, 1'b0, '0);
    applyStimulus(1'b0, '0, 1'b1, 10'h0F1);
    checkOutput("t2_mismatch", 32'(mismatch), 1);
    checkOutput("t2_err", 32'(err_cnt), 1);
    checkOutput("t2_fault", 32'(fault), 1);
    applyStimulus(1'b1, 10'h033, 1'b0, '0);
    applyStimulus(1'b0, '0, 1'b1, 10'h033);
    checkOutput("t2_match", 32'(match), 1);
    checkOutput("t2_fault_held", 32'(fault), 1);
    checkOutput("t2_pass", 32'(pass_cnt), 4);

    // Overflow on the ninth push, then push+pop while full.
    doReset();
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 10'(10'h10 + i), 1'b0, '0);
    checkOutput("t3_level", 32'(level), 8);
    checkOutput("t3_overflow", 32'(overflow), 1);
    applyStimulus(1'b1, 10'h3C, 1'b1, 10'h10);
    checkOutput("t3_level_full", 32'(level), 8);
    checkOutput("t3_match", 32'(match), 1);
    for (int i = 1; i < 8; i++) applyStimulus(1'b0, '0, 1'b1, 10'(10'h10 + i));
    applyStimulus(1'b0, '0, 1'b1, 10'h3C);
    checkOutput("t3_pass", 32'(pass_cnt), 9);
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("t3_drained", 32'(level), 0);

    // Pop while empty alongside a push: underflow, push still lands.
    doReset();
    applyStimulus(1'b1, 10'h3FF, 1'b1, 10'h3FF);
    checkOutput("t4_underflow", 32'(underflow), 1);
    checkOutput("t4_match", 32'(match), 0);
    checkOutput("t4_mismatch", 32'(mismatch), 0);
    checkOutput("t4_level", 32'(level), 1);

    // Timeout exactly one edge after the head age reaches MAX_LAT.
    doReset();
    applyStimulus(1'b1, 10'h0AA, 1'b0, '0);
    for (int i = 0; i < MAX_LAT; i++) applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("t5_no_timeout_yet", 32'(timeout), 0);
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("t5_timeout", 32'(timeout), 1);
    checkOutput("t5_fault", 32'(fault), 1);

    doReset();
    applyStimulus(1'b1, 10'h0AA, 1'b0, '0);
    for (int i = 0; i < 13; i++) applyStimulus(1'b0, '0, 1'b0, '0);
    applyStimulus(1'b0, '0, 1'b1, 10'h0AA);
    checkOutput("t5b_match", 32'(match), 1);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("t5b_timeout", 32'(timeout), 0);
    checkOutput("t5b_fault", 32'(fault), 0);

    // Reset mid-operation discards queued words.
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 10'(10'h200 + i), 1'b0, '0);
    checkOutput("t6_level4", 32'(level), 4);
    arst_n = 1'b0;
    applyStimulus(1'b1, 10'h111, 1'b0, '0);
    arst_n = 1'b1;
    checkOutput("t6_level", 32'(level), 0);
    checkOutput("t6_flags", 32'({overflow, underflow, timeout, fault}), 0);
    checkOutput("t6_cnts", 32'({pass_cnt, err_cnt}), 0);
    applyStimulus(1'b0, '0, 1'b1, 10'h200);
    checkOutput("t6_underflow", 32'(underflow), 1);
    checkOutput("t6_no_pulse", 32'({match, mismatch}), 0);

    applyStimulus(1'b0, '0, 1'b0, '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
